piradip_sample_buffer_sequencer: RTL
====================================

// Module: piradip_sample_buffer_sequencer
// PURPOSE
//  AXI4-Lite manager that sequences piradip_axis_sample_buffer_out playback over its control port.
//  On go: programs the start/end sample window, enables the buffer, holds it for a dwell time,
//  then disables it; repeats REPEAT times. Sits between the PS/trigger logic and the buffer's axilite port.
//  Address map targeted: CTRL @0x00 (3 = enable+run, 0 = stop), START @0x04, END @0x08.
// PARAMETERS
//  ADDR_WIDTH   32  AXI-Lite address width
//  DATA_WIDTH   32  AXI-Lite data width; only 32 is supported
//  DWELL_WIDTH  32  width of dwell cycle counter
//  REP_WIDTH    16  width of repeat counter
//  CTRL_RUN     3   value written to CTRL to enable playback
// PORTS
//  clk          in   1            single clock; all logic and AXI-Lite on this edge
//  resetn       in   1            asynchronous, active-low reset
//  go           in   1            1-cycle start pulse; seg_*/dwell/repeat sampled this cycle
//  abort        in   1            level; request early stop
//  seg_start    in   ADDR_WIDTH   value for START reg
//  seg_end      in   ADDR_WIDTH   value for END reg
//  dwell        in   DWELL_WIDTH  clk cycles to stay enabled per repeat
//  repeat_cnt   in   REP_WIDTH    number of playbacks; 0 = none
//  busy         out  1            high from go-accept until return to IDLE
//  done         out  1            1-cycle pulse on return to IDLE
//  error        out  1            sticky; set on any bresp!=OKAY, cleared on accepted go
//  m_axil_aw*   out/in            awaddr[ADDR_WIDTH], awprot[3]=0, awvalid / awready
//  m_axil_w*    out/in            wdata[32], wstrb[4]=4'hF, wvalid / wready
//  m_axil_b*    in/out            bresp[2], bvalid / bready
//  m_axil_ar*/r* out/in           read channel unused: arvalid=0, rready=0, araddr=0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, error, awvalid, wvalid, bready = 0; counters, awaddr, wdata = 0.
//  go accepted only in IDLE; ignored while busy. Inputs latched on accept; later changes have no effect.
//  States: IDLE -> W_START -> W_END -> W_ON -> DWELL -> W_OFF -> (rep left ? W_ON : FIN) -> IDLE.
//  Write sub-sequence (each W_* state): cycle after entry assert awvalid+wvalid together;
//   each drops independently the cycle after its own ready handshake; bready=1 once both done;
//   state advances the cycle after bvalid&&bready. No new AW before previous B received (1 outstanding).
//  Latency: go -> awvalid of START write = 1 cycle. done pulses in the cycle IDLE is re-entered.
//  DWELL: counter loads dwell on B of W_ON, decrements per cycle; W_OFF entered when 0.
//   dwell=0 -> W_OFF directly after W_ON's B. Rep counter decrements on W_OFF's B.
//  repeat_cnt=0 -> no AXI traffic; go -> FIN -> IDLE, done 2 cycles after go.
//  abort: in DWELL -> W_OFF next cycle, then FIN (no further repeats). During W_START/W_END ->
//   finish current write, then FIN (buffer never enabled). During W_ON -> finish, then W_OFF, FIN.
//   During W_OFF -> finish, FIN. An in-flight AXI write is never truncated (valid held until ready).
//  bresp!=0: error set; on W_START/W_END/W_ON -> W_OFF then FIN; on W_OFF -> FIN.
//  abort and go in same cycle in IDLE: go accepted, abort honoured next cycle per rules above.
//  resetn asserted mid-transaction: all valids drop immediately (async); no completion attempted.
//  Counters saturate at 0; no wrap.
// STRUCTURE
//  Package piradip_seq_pkg: state enum seq_state_t, REG_CTRL/REG_START/REG_END offsets, AXI resp codes.
//  Sub-module piradip_axil_single_write: one-outstanding AXI-Lite write engine
//   (req, addr, data -> busy, done, resp); sequencer FSM drives it.
// TESTING
//  1 go, start=0x000, end=0x3FF, dwell=10, repeat=1 -> writes 0x04=0, 0x08=0x3FF, 0x00=3, 10 cycles, 0x00=0; done once.
//  2 repeat=3, dwell=5 -> START/END once, then 3x (CTRL=3, CTRL=0) pairs; busy high throughout.
//  3 abort raised 2 cycles into DWELL with repeat=4 -> CTRL=0 write next, no further CTRL=3; done, error=0.
//  4 subordinate returns bresp=2'b10 on END write -> error=1, next write CTRL=0, done; new go clears error.
//  5 awready held low 20 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held, data stable.
//  6 repeat=0 -> no awvalid ever, done 2 cycles after go; go while busy -> ignored, one done only.

Source files
------------

// File: rtl/piradip_seq_pkg.sv
// Shared types and constants for the sample-buffer sequencer: FSM states,
// buffer register offsets and AXI response codes.
package piradip_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_START,
    S_W_END,
    S_W_ON,
    S_DWELL,
    S_W_OFF,
    S_FIN
  } seq_state_t;

  localparam logic [31:0] REG_CTRL  = 32'h0000_0000;
  localparam logic [31:0] REG_START = 32'h0000_0004;
  localparam logic [31:0] REG_END   = 32'h0000_0008;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/piradip_sample_buffer_sequencer_if.sv
// AXI4-Lite bundle between the sequencer (master) and the sample buffer's control port (slave).
interface piradip_sample_buffer_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/piradip_sample_buffer_sequencer_write.sv
// Single-outstanding AXI4-Lite write engine: a req pulse launches AW and W together,
// each channel retires on its own handshake, then the B response is collected.
module piradip_axil_single_write #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            resp,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic awvalid_reg, wvalid_reg, bready_reg;
  logic aw_clear, w_clear, b_hs;

  // A channel counts as retired if it is already idle or handshakes this cycle.
  assign aw_clear = !awvalid_reg || awready;
  assign w_clear  = !wvalid_reg || wready;
  assign b_hs     = bvalid && bready_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
    end else begin
      if (req) begin
        awaddr_reg  <= addr;
        wdata_reg   <= data;
        awvalid_reg <= 1'b1;
        wvalid_reg  <= 1'b1;
      end else begin
        if (awready) awvalid_reg <= 1'b0;
        if (wready)  wvalid_reg  <= 1'b0;
      end
      if (b_hs) begin
        bready_reg <= 1'b0;
      end else if ((awvalid_reg || wvalid_reg) && aw_clear && w_clear) begin
        bready_reg <= 1'b1;
      end
    end
  end

  assign awaddr  = awaddr_reg;
  assign awvalid = awvalid_reg;
  assign wdata   = wdata_reg;
  assign wvalid  = wvalid_reg;
  assign bready  = bready_reg;
  assign busy    = awvalid_reg || wvalid_reg || bready_reg;
  assign done    = b_hs;
  assign resp    = bresp;
endmodule

// File: rtl/piradip_sample_buffer_sequencer.sv
// Playback sequencer: programs the sample window of the buffer, then toggles its
// CTRL register on/off with a dwell between, for the requested number of repeats.
module piradip_sample_buffer_sequencer
  import piradip_seq_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DWELL_WIDTH = 32,
  parameter int          REP_WIDTH   = 16,
  parameter logic [31:0] CTRL_RUN    = 32'd3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   go,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  seg_start,
  input  logic [ADDR_WIDTH-1:0]  seg_end,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [REP_WIDTH-1:0]   repeat_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  piradip_sample_buffer_sequencer_if.master m_axil
);
  seq_state_t state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  seg_start_reg, seg_start_next, seg_end_reg, seg_end_next;
  logic [DWELL_WIDTH-1:0] dwell_reg, dwell_next, dwell_cnt_reg, dwell_cnt_next;
  logic [REP_WIDTH-1:0]   rep_cnt_reg, rep_cnt_next;
  logic stop_reg, stop_next, error_reg, error_next, done_reg, done_next;
  logic wr_req, wr_busy, wr_done, wr_bad, stop_now;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            wr_resp;
  logic                  unused_sigs;

  assign wr_bad   = wr_done && (wr_resp != RESP_OKAY);
  assign stop_now = stop_reg || abort;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      seg_start_reg <= '0;
      seg_end_reg   <= '0;
      dwell_reg     <= '0;
      dwell_cnt_reg <= '0;
      rep_cnt_reg   <= '0;
      stop_reg      <= 1'b0;
      error_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      seg_start_reg <= seg_start_next;
      seg_end_reg   <= seg_end_next;
      dwell_reg     <= dwell_next;
      dwell_cnt_reg <= dwell_cnt_next;
      rep_cnt_reg   <= rep_cnt_next;
      stop_reg      <= stop_next;
      error_reg     <= error_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    seg_start_next = seg_start_reg;
    seg_end_next   = seg_end_reg;
    dwell_next     = dwell_reg;
    dwell_cnt_next = dwell_cnt_reg;
    rep_cnt_next   = rep_cnt_reg;
    // A bad response is treated like an abort: shut the buffer off and finish.
    stop_next      = stop_reg || ((state_reg != S_IDLE) && abort) || wr_bad;
    error_next     = error_reg || wr_bad;
    done_next      = 1'b0;
    wr_req         = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    case (state_reg)
      S_IDLE: begin
        if (go) begin
          seg_start_next = seg_start;
          seg_end_next   = seg_end;
          dwell_next     = dwell;
          rep_cnt_next   = repeat_cnt;
          stop_next      = 1'b0;
          error_next     = 1'b0;
          if (repeat_cnt == '0) begin
            state_next = S_FIN;
          end else begin
            state_next = S_W_START;
            wr_req     = 1'b1;
            wr_addr    = ADDR_WIDTH'(REG_START);
            wr_data    = DATA_WIDTH'(seg_start);
          end
        end
      end
      S_W_START, S_W_END: begin
        if (wr_done) begin
          if (wr_bad) begin
            state_next = S_W_OFF;
            wr_req     = 1'b1;
            wr_addr    = ADDR_WIDTH'(REG_CTRL);
          end else if (stop_now) begin
            state_next = S_FIN;
          end else if (state_reg == S_W_START) begin
            state_next = S_W_END;
            wr_req     = 1'b1;
            wr_addr    = ADDR_WIDTH'(REG_END);
            wr_data    = DATA_WIDTH'(seg_end_reg);
          end else begin
            state_next = S_W_ON;
            wr_req     = 1'b1;
            wr_addr    = ADDR_WIDTH'(REG_CTRL);
            wr_data    = DATA_WIDTH'(CTRL_RUN);
          end
        end
      end
      S_W_ON: begin
        if (wr_done) begin
          if (wr_bad || stop_now || (dwell_reg == '0)) begin
            state_next = S_W_OFF;
            wr_req     = 1'b1;
            wr_addr    = ADDR_WIDTH'(REG_CTRL);
          end else begin
            state_next     = S_DWELL;
            dwell_cnt_next = dwell_reg;
          end
        end
      end
      S_DWELL: begin
        dwell_cnt_next = (dwell_cnt_reg == '0) ? '0 : dwell_cnt_reg - DWELL_WIDTH'(1);
        if (stop_now || (dwell_cnt_next == '0)) begin
          state_next = S_W_OFF;
          wr_req     = 1'b1;
          wr_addr    = ADDR_WIDTH'(REG_CTRL);
        end
      end
      S_W_OFF: begin
        if (wr_done) begin
          rep_cnt_next = (rep_cnt_reg == '0) ? '0 : rep_cnt_reg - REP_WIDTH'(1);
          if (wr_bad || stop_now || (rep_cnt_next == '0)) begin
            state_next = S_FIN;
          end else begin
            state_next = S_W_ON;
            wr_req     = 1'b1;
            wr_addr    = ADDR_WIDTH'(REG_CTRL);
            wr_data    = DATA_WIDTH'(CTRL_RUN);
          end
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  piradip_axil_single_write #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_write (
    .clk     (clk),
    .resetn  (resetn),
    .req     (wr_req),
    .addr    (wr_addr),
    .data    (wr_data),
    .busy    (wr_busy),
    .done    (wr_done),
    .resp    (wr_resp),
    .awaddr  (m_axil.awaddr),
    .awvalid (m_axil.awvalid),
    .awready (m_axil.awready),
    .wdata   (m_axil.wdata),
    .wvalid  (m_axil.wvalid),
    .wready  (m_axil.wready),
    .bresp   (m_axil.bresp),
    .bvalid  (m_axil.bvalid),
    .bready  (m_axil.bready)
  );

  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_wstrb
    assign m_axil.wstrb[gi] = 1'b1;
  end

  assign m_axil.awprot  = 3'b000;
  assign m_axil.araddr  = '0;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = 1'b0;
  assign m_axil.rready  = 1'b0;

  // Read channel is never used; the engine busy flag is informational only.
  assign unused_sigs = ^{wr_busy, m_axil.arready, m_axil.rdata, m_axil.rresp, m_axil.rvalid};

  assign busy  = (state_reg != S_IDLE);
  assign done  = done_reg;
  assign error = error_reg;
endmodule
